clz_denorm: RTL
===============

// Module: clz_denorm
// PURPOSE
//  Inverse of the leading-zero counter: restores a left-normalised operand to its
//  original alignment by right-shifting it by a leading-zero count.
//  Pipelined log-shifter, one stage per count bit, valid/ready on both sides.
//  Sits after normalised arithmetic; it consumes the count and zero-flag that the
//  leading-zero counter produced for the same operand.
// PARAMETERS
//  WIDTH   16   operand width; power of two, >= 4
//  CNT_W   (localparam) `CLOG2(WIDTH); count width and pipeline depth
// PORTS
//  clk        in   1       single clock; all state on rising edge
//  rst        in   1       asynchronous, active-high reset
//  in_valid   in   1       input beat offered
//  in_ready   out  1       input beat accepted when in_valid & in_ready
//  in_data    in   WIDTH   normalised operand
//  in_count   in   CNT_W   right-shift amount (leading-zero count), 0..WIDTH-1
//  in_zero    in   1       operand was all zeros (counter valid bit low)
//  out_valid  out  1       result beat present
//  out_ready  in   1       result consumed when out_valid & out_ready
//  out_data   out  WIDTH   de-normalised operand
//  out_sticky out  1       OR of every 1 bit shifted out past bit 0
//  out_zero   out  1       in_zero carried through
// BEHAVIOUR
//  - Reset: every stage valid = 0, all data/count/sticky/zero regs = 0;
//    out_valid = 0, out_data = 0, out_sticky = 0, out_zero = 0;
//    in_ready = 1 after reset deasserts.
//  - Reset mid-operation: all in-flight beats are discarded; no beat is emitted
//    after reset releases unless it was accepted after release.
//  - Stage k (k = 0..CNT_W-1) registers: valid, data, remaining count, sticky, zero.
//    Stage k shifts right by 2**k when count bit k is set and ORs the bits
//    dropped by that shift into sticky. Stage 0 samples the input port with
//    sticky = 0. The last stage drives the out_* ports.
//  - Per-stage advance: stage k loads from its upstream when it is empty OR is
//    handing its own beat on in the same cycle. Bubbles collapse.
//    in_ready = !v0 | adv0. Combinational ready chain back from out_ready; no
//    combinational path from in_valid to out_*.
//  - Latency: CNT_W cycles from acceptance to out_valid with out_ready held high.
//    Throughput is 1 beat/cycle. Capacity is CNT_W beats.
//  - Output stall: while out_valid & !out_ready, all out_* hold stable.
//    Upstream stages keep filling until full, then in_ready = 0.
//  - Simultaneous accept/emit at full occupancy: the pipeline shifts as one
//    step, nothing is lost or duplicated, and order is strictly FIFO.
//  - Width rules: shifts are logical (zero fill). in_count is unsigned.
//    in_count = 0 passes in_data unchanged with sticky = 0. Counts need no
//    saturation because CNT_W bits cover exactly 0..WIDTH-1.
//  - in_zero = 1: out_data forced to 0, out_sticky = 0, out_zero = 1,
//    regardless of in_data/in_count. The beat still occupies a pipeline slot.
//  - Ports not qualified by valid (data when valid = 0) hold their previous
//    value; they are not required to be zero.
// TESTING  (WIDTH = 16, CNT_W = 4)
//  1. in_data = 16'h8000, count = 3, out_ready = 1 -> 4 cycles later:
//     out_data = 16'h1000, sticky = 0, zero = 0.
//  2. Sticky: (16'h8001, 1) -> 16'h4000 with sticky = 1.
//     (16'hFFFF, 15) -> 16'h0001 with sticky = 1.
//     (16'hF000, 12) -> 16'h000F with sticky = 0.
//  3. Streaming: 32 back-to-back random beats with out_ready = 1 -> 32 results
//     in order, one per cycle, each matching a reference model (data >> count).
//  4. Back-pressure: out_ready = 0 for 10 cycles while in_valid = 1 -> exactly
//     4 beats accepted, in_ready = 0 thereafter, out_* stable. Release ->
//     all beats drain in order, none lost or duplicated.
//  5. Zero flag: in_zero = 1 with data 16'hABCD and count 5 ->
//     out_data = 0, sticky = 0, out_zero = 1.
//  6. Reset: assert rst asynchronously with 3 beats in flight -> out_valid = 0
//     immediately. After release, no stale beat appears and a new beat returns
//     with 4-cycle latency.

Source files
------------

// File: rtl/clz_denorm.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | clz_denorm                                                               |
// | Pipelined right log-shifter that undoes leading-zero normalisation.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module clz_denorm #(
   parameter  int WIDTH = 16,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [CNT_W-1:0] in_count,
   input  logic             in_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sticky,
   output logic             out_zero
);
   localparam int c_last = CNT_W - 1;

   logic [CNT_W-1:0] w_valid;
   logic [CNT_W-1:0] w_sticky;
   logic [CNT_W-1:0] w_zero;
   logic [CNT_W-1:0] w_ready;
   logic [CNT_W-1:0] w_adv;
   logic [WIDTH-1:0] w_data [CNT_W];
   logic [CNT_W-1:0] w_cnt  [CNT_W];
   logic             w_unused;

   genvar k;
   for (k = 0; k < CNT_W; k++) begin : g_stage
      localparam int c_shift = 1 << k;

      logic             w_src_valid;
      logic [WIDTH-1:0] w_src_data;
      logic [CNT_W-1:0] w_src_cnt;
      logic             w_src_sticky;
      logic             w_src_zero;
      logic [WIDTH-1:0] w_shifted;
      logic             w_dropped;

      logic             r_valid;
      logic [WIDTH-1:0] r_data;
      logic [CNT_W-1:0] r_cnt;
      logic             r_sticky;
      logic             r_zero;

      if (k == 0) begin : g_head
         // A zero operand enters as data 0 / count 0, so it exits as 0 with no sticky
         assign w_src_valid  = in_valid;
         assign w_src_data   = in_zero ? '0 : in_data;
         assign w_src_cnt    = in_zero ? '0 : in_count;
         assign w_src_sticky = 1'b0;
         assign w_src_zero   = in_zero;
      end else begin : g_link
         assign w_src_valid  = w_valid[k-1];
         assign w_src_data   = w_data[k-1];
         assign w_src_cnt    = w_cnt[k-1];
         assign w_src_sticky = w_sticky[k-1];
         assign w_src_zero   = w_zero[k-1];
      end

      if (k == c_last) begin : g_tail
         assign w_adv[k] = r_valid & out_ready;
      end else begin : g_body
         assign w_adv[k] = r_valid & w_ready[k+1];
      end

      assign w_ready[k] = ~r_valid | w_adv[k];
      assign w_shifted  = w_src_cnt[k] ? (w_src_data >> c_shift) : w_src_data;
      assign w_dropped  = w_src_cnt[k] & (|w_src_data[c_shift-1:0]);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
            r_zero   <= 1'b0;
         end else if (w_ready[k]) begin
            r_valid <= w_src_valid;
            if (w_src_valid) begin
               r_data   <= w_shifted;
               r_cnt    <= w_src_cnt;
               r_sticky <= w_src_sticky | w_dropped;
               r_zero   <= w_src_zero;
            end
         end
      end

      assign w_valid[k]  = r_valid;
      assign w_data[k]   = r_data;
      assign w_cnt[k]    = r_cnt;
      assign w_sticky[k] = r_sticky;
      assign w_zero[k]   = r_zero;
   end

   // The final stage's count has no consumer
   assign w_unused = ^w_cnt[c_last];

   assign in_ready   = w_ready[0];
   assign out_valid  = w_valid[c_last];
   assign out_data   = w_data[c_last];
   assign out_sticky = w_sticky[c_last];
   assign out_zero   = w_zero[c_last];

endmodule
`default_nettype wire
